// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// imem_ready acknowledges the request and qualifies imem_rdata in the same cycle.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32 IF stage: owns PCF, sequences imem requests through wait states and redirects,
// and loads the IF/ID register under hazard-unit stall/flush control.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          StallF,
    input  logic          StallD,
    input  logic          FlushD,
    input  logic          PCSrcE,
    input  logic [31:0]   PCTargetE,
    fetch_stage_if.master imem,
    output logic [31:0]   InstrD,
    output logic [31:0]   PCD,
    output logic [31:0]   PCPlus4D,
    output logic          ValidD
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [31:0] pcf_r, pcf_nxt_s;
    logic [31:0] tgt_r, tgt_nxt_s;
    logic [31:0] buf_r, buf_nxt_s;
    logic [31:0] instr_d_r, pc_d_r, pc_plus4_d_r;
    logic        valid_d_r;
    logic        consume_s;
    logic [31:0] fetched_s;
    logic [31:0] target_s;
    logic [31:0] pcf_plus4_s;

    assign target_s    = align_word(PCTargetE);
    assign pcf_plus4_s = pcf_r + 32'd4;

    assign imem.imem_req  = (state_r != ST_HOLD);
    assign imem.imem_addr = align_word(pcf_r);

    assign InstrD   = instr_d_r;
    assign PCD      = pc_d_r;
    assign PCPlus4D = pc_plus4_d_r;
    assign ValidD   = valid_d_r;

    // Next-state logic: redirects always win over StallF; DRAIN waits out the abandoned-address response.
    always_comb begin
        state_nxt_s = state_r;
        pcf_nxt_s   = pcf_r;
        tgt_nxt_s   = tgt_r;
        buf_nxt_s   = buf_r;
        consume_s   = 1'b0;
        fetched_s   = imem.imem_rdata;
        case (state_r)
            ST_RUN: begin
                if (PCSrcE) begin
                    if (imem.imem_ready) begin
                        pcf_nxt_s = target_s;
                    end else begin
                        tgt_nxt_s   = target_s;
                        state_nxt_s = ST_DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    if (!StallF) begin
                        consume_s = 1'b1;
                        pcf_nxt_s = pcf_plus4_s;
                    end else begin
                        buf_nxt_s   = imem.imem_rdata;
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    pcf_nxt_s = pcf_r;
                end
            end
            ST_HOLD: begin
                if (PCSrcE) begin
                    pcf_nxt_s   = target_s;
                    state_nxt_s = ST_RUN;
                end else if (!StallF) begin
                    consume_s   = 1'b1;
                    fetched_s   = buf_r;
                    pcf_nxt_s   = pcf_plus4_s;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (imem.imem_ready) begin
                    pcf_nxt_s   = PCSrcE ? target_s : tgt_r;
                    state_nxt_s = ST_RUN;
                end else if (PCSrcE) begin
                    tgt_nxt_s = target_s;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                pcf_nxt_s   = RESET_PC;
            end
        endcase
    end

    // Fetch-side state: FSM, PC, pending redirect target and stall buffer.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
            pcf_r   <= RESET_PC;
            tgt_r   <= 32'h0000_0000;
            buf_r   <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            pcf_r   <= pcf_nxt_s;
            tgt_r   <= tgt_nxt_s;
            buf_r   <= buf_nxt_s;
        end
    end

    // IF/ID register; anything that is not a consumed instruction becomes a bubble.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            instr_d_r    <= NOP_INSTR;
            pc_d_r       <= 32'h0000_0000;
            pc_plus4_d_r <= 32'h0000_0000;
            valid_d_r    <= 1'b0;
        end else if (FlushD) begin
            instr_d_r    <= NOP_INSTR;
            pc_d_r       <= 32'h0000_0000;
            pc_plus4_d_r <= 32'h0000_0000;
            valid_d_r    <= 1'b0;
        end else if (StallD) begin
            instr_d_r    <= instr_d_r;
            pc_d_r       <= pc_d_r;
            pc_plus4_d_r <= pc_plus4_d_r;
            valid_d_r    <= valid_d_r;
        end else if (consume_s) begin
            instr_d_r    <= fetched_s;
            pc_d_r       <= pcf_r;
            pc_plus4_d_r <= pcf_plus4_s;
            valid_d_r    <= 1'b1;
        end else begin
            instr_d_r    <= NOP_INSTR;
            pc_d_r       <= 32'h0000_0000;
            pc_plus4_d_r <= 32'h0000_0000;
            valid_d_r    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem model returns addr ^ 0xA5A50000 with a controllable ready.
module tb_fetch_stage;

    logic        CLK;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic        ready_v;
    int          n_cmp;
    int          n_err;

    fetch_stage_if bus ();

    assign bus.imem_ready = ready_v;
    assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

    fetch_stage dut (
        .CLK(CLK), .rst(rst),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem(bus.master),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        step();
        n_cmp++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0h want 0", ValidD); end
        n_cmp++; if (InstrD !== 32'h0000_0013) begin n_err++; $display("FAIL reset_instr got %h want 00000013", InstrD); end
        n_cmp++; if (PCD !== 32'h0) begin n_err++; $display("FAIL reset_pcd got %h want 0", PCD); end
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL reset_req got %0h want 1", bus.imem_req); end
        rst = 1'b1;
    endtask

    task automatic test_straight();
        step();
        n_cmp++; if (InstrD !== 32'hA5A5_0000 || PCD !== 32'h0 || ValidD !== 1'b1)
            begin n_err++; $display("FAIL straight0 got %h/%h/%0h want a5a50000/0/1", InstrD, PCD, ValidD); end
        n_cmp++; if (PCPlus4D !== 32'h4) begin n_err++; $display("FAIL straight0_p4 got %h want 4", PCPlus4D); end
        step();
        n_cmp++; if (InstrD !== 32'hA5A5_0004 || PCD !== 32'h4 || ValidD !== 1'b1)
            begin n_err++; $display("FAIL straight1 got %h/%h/%0h want a5a50004/4/1", InstrD, PCD, ValidD); end
        n_cmp++; if (bus.imem_addr !== 32'h8) begin n_err++; $display("FAIL straight_addr got %h want 8", bus.imem_addr); end
    endtask

    task automatic test_wait_states();
        ready_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (ValidD !== 1'b0 || InstrD !== 32'h0000_0013)
                begin n_err++; $display("FAIL wait_bubble%0d got %0h/%h want 0/00000013", i, ValidD, InstrD); end
            n_cmp++; if (bus.imem_addr !== 32'h8 || bus.imem_req !== 1'b1)
                begin n_err++; $display("FAIL wait_addr%0d got %h/%0h want 8/1", i, bus.imem_addr, bus.imem_req); end
        end
        ready_v = 1'b1;
        step();
        n_cmp++; if (PCD !== 32'h8 || InstrD !== 32'hA5A5_0008 || ValidD !== 1'b1)
            begin n_err++; $display("FAIL wait_done got %h/%h/%0h want 8/a5a50008/1", PCD, InstrD, ValidD); end
    endtask

    task automatic test_stall_hold();
        step();
        StallF = 1'b1; StallD = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL hold_req%0d got %0h want 0", i, bus.imem_req); end
            n_cmp++; if (PCD !== 32'hC || InstrD !== 32'hA5A5_000C || ValidD !== 1'b1)
                begin n_err++; $display("FAIL hold_frozen%0d got %h/%h/%0h want c/a5a5000c/1", i, PCD, InstrD, ValidD); end
        end
        StallF = 1'b0; StallD = 1'b0;
        step();
        n_cmp++; if (PCD !== 32'h10 || InstrD !== 32'hA5A5_0010 || ValidD !== 1'b1)
            begin n_err++; $display("FAIL hold_release got %h/%h/%0h want 10/a5a50010/1", PCD, InstrD, ValidD); end
        step();
        n_cmp++; if (PCD !== 32'h14) begin n_err++; $display("FAIL hold_next got %h want 14", PCD); end
    endtask

    task automatic test_redirect();
        step(); step();
        n_cmp++; if (bus.imem_addr !== 32'h20) begin n_err++; $display("FAIL redir_pre got %h want 20", bus.imem_addr); end
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0103;
        step();
        PCSrcE = 1'b0;
        n_cmp++; if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_addr got %h want 100", bus.imem_addr); end
        n_cmp++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL redir_drop got %0h want 0", ValidD); end
        step();
        n_cmp++; if (PCD !== 32'h100 || InstrD !== 32'hA5A5_0100 || ValidD !== 1'b1)
            begin n_err++; $display("FAIL redir_pcd got %h/%h/%0h want 100/a5a50100/1", PCD, InstrD, ValidD); end
    endtask

    task automatic test_drain();
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        step();
        ready_v = 1'b0; PCTargetE = 32'h200;
        step();
        n_cmp++; if (bus.imem_addr !== 32'h40 || bus.imem_req !== 1'b1)
            begin n_err++; $display("FAIL drain_addr0 got %h/%0h want 40/1", bus.imem_addr, bus.imem_req); end
        PCTargetE = 32'h300;
        step();
        n_cmp++; if (bus.imem_addr !== 32'h40 || ValidD !== 1'b0)
            begin n_err++; $display("FAIL drain_addr1 got %h/%0h want 40/0", bus.imem_addr, ValidD); end
        PCSrcE = 1'b0; ready_v = 1'b1;
        step();
        n_cmp++; if (bus.imem_addr !== 32'h300 || ValidD !== 1'b0)
            begin n_err++; $display("FAIL drain_exit got %h/%0h want 300/0", bus.imem_addr, ValidD); end
        step();
        n_cmp++; if (PCD !== 32'h300 || ValidD !== 1'b1)
            begin n_err++; $display("FAIL drain_target got %h/%0h want 300/1", PCD, ValidD); end
    endtask

    task automatic test_flush();
        FlushD = 1'b1; StallD = 1'b1;
        step();
        FlushD = 1'b0; StallD = 1'b0;
        n_cmp++; if (ValidD !== 1'b0 || InstrD !== 32'h0000_0013 || PCD !== 32'h0 || PCPlus4D !== 32'h0)
            begin n_err++; $display("FAIL flush got %0h/%h/%h/%h want 0/00000013/0/0", ValidD, InstrD, PCD, PCPlus4D); end
    endtask

    task automatic test_wrap();
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
        step();
        PCSrcE = 1'b0;
        n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr got %h want fffffffc", bus.imem_addr); end
        step();
        n_cmp++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || InstrD !== 32'h5A5A_FFFC)
            begin n_err++; $display("FAIL wrap_ifid got %h/%h/%h want fffffffc/0/5a5afffc", PCD, PCPlus4D, InstrD); end
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next got %h want 0", bus.imem_addr); end
    endtask

    task automatic test_reset_drain();
        step(); step();
        StallD = 1'b1; ready_v = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h500;
        step();
        PCSrcE = 1'b0;
        n_cmp++; if (ValidD !== 1'b1 || PCD !== 32'h4 || bus.imem_addr !== 32'h8)
            begin n_err++; $display("FAIL rdrain_pre got %0h/%h/%h want 1/4/8", ValidD, PCD, bus.imem_addr); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (ValidD !== 1'b0 || InstrD !== 32'h0000_0013 || PCD !== 32'h0)
            begin n_err++; $display("FAIL rdrain_async got %0h/%h/%h want 0/00000013/0", ValidD, InstrD, PCD); end
        StallD = 1'b0; ready_v = 1'b1;
        step();
        rst = 1'b1;
        n_cmp++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1)
            begin n_err++; $display("FAIL rdrain_addr got %h/%0h want 0/1", bus.imem_addr, bus.imem_req); end
        step();
        n_cmp++; if (PCD !== 32'h0 || InstrD !== 32'hA5A5_0000 || ValidD !== 1'b1)
            begin n_err++; $display("FAIL rdrain_restart got %h/%h/%0h want 0/a5a50000/1", PCD, InstrD, ValidD); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'h0; ready_v = 1'b1;
        test_reset();
        test_straight();
        test_wait_states();
        test_stall_hold();
        test_redirect();
        test_drain();
        test_flush();
        test_wrap();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
